// File: rtl/rte_pkg.sv
// Shared definitions for reg_transfer_engine: opcodes, FSM states, legality check.
// RTE_MULDIV_EN enables MUL/DIV and the T_DIV state.
package rte_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd4;
    localparam logic [OP_W-1:0] OP_SHRA = 5'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd6;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd9;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd10;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd11;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd12;
    localparam logic [OP_W-1:0] OP_MFHI = 5'd13;
    localparam logic [OP_W-1:0] OP_MFLO = 5'd14;

    // Every quotient bit is set on divide-by-zero.
    localparam logic DIV0_Q_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TY   = 3'd1,
        ST_TZ   = 3'd2,
        ST_WB   = 3'd3
`ifdef RTE_MULDIV_EN
        , ST_TDIV = 3'd4
`endif
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
`ifdef RTE_MULDIV_EN
        return op <= OP_MFLO;
`else
        return (op <= OP_MFLO) && (op != OP_MUL) && (op != OP_DIV);
`endif
    endfunction

endpackage

// File: rtl/rte_alu.sv
// Combinational ALU: (Y, bus, op) -> result; MUL present only with RTE_MULDIV_EN.
// RES_W is 2*DATA_W when the multiplier exists, DATA_W otherwise.
module rte_alu
    import rte_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RES_W  = 2 * DATA_W
) (
    input  logic [DATA_W-1:0] i_y,
    input  logic [DATA_W-1:0] i_bus,
    input  logic [OP_W-1:0]   i_op,
    output logic [RES_W-1:0]  o_res
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam int unsigned DW2  = 2 * DATA_W;

    logic [SH_W-1:0]   w_amt;
    logic [DW2-1:0]    w_dbl;
    logic [DATA_W-1:0] w_lo;

    assign w_amt = i_bus[SH_W-1:0];
    assign w_dbl = {i_y, i_y};

`ifdef RTE_MULDIV_EN
    logic signed [RES_W-1:0] w_prod;
    assign w_prod = $signed(i_y) * $signed(i_bus);
`endif

    // Rotates take the matching half of the doubled operand after the shift.
    always_comb begin
        w_lo = '0;
        case (i_op)
            OP_ADD:  w_lo = i_y + i_bus;
            OP_SUB:  w_lo = i_y - i_bus;
            OP_AND:  w_lo = i_y & i_bus;
            OP_OR:   w_lo = i_y | i_bus;
            OP_SHR:  w_lo = i_y >> w_amt;
            OP_SHRA: w_lo = DATA_W'($signed(i_y) >>> w_amt);
            OP_SHL:  w_lo = i_y << w_amt;
            OP_ROR:  w_lo = DATA_W'(w_dbl >> w_amt);
            OP_ROL:  w_lo = DATA_W'((w_dbl << w_amt) >> DATA_W);
            OP_NEG:  w_lo = -i_y;
            OP_NOT:  w_lo = ~i_y;
            default: w_lo = '0;
        endcase
    end

    always_comb begin
        o_res = RES_W'(w_lo);
`ifdef RTE_MULDIV_EN
        if (i_op == OP_MUL) begin
            o_res = $unsigned(w_prod);
        end
`endif
    end

endmodule

// File: rtl/reg_transfer_engine.sv
// Single-bus register-transfer datapath with micro-sequencer (Y-load, Z-load, writeback).
// RTE_MULDIV_EN adds the signed multiplier and the iterative restoring divider.
module reg_transfer_engine
    import rte_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 16,
    localparam int unsigned RIDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [RIDX_W-1:0] req_ra,
    input  logic [RIDX_W-1:0] req_rb,
    input  logic [RIDX_W-1:0] req_rc,
    input  logic              ld_valid,
    input  logic [RIDX_W-1:0] ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [RIDX_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

`ifdef RTE_MULDIV_EN
    localparam int unsigned Z_W = 2 * DATA_W;
`else
    localparam int unsigned Z_W = DATA_W;
`endif
    localparam int unsigned SH_W = $clog2(DATA_W);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [OP_W-1:0]   r_op;
    logic [RIDX_W-1:0] r_ra, r_rb, r_rc;
    logic [DATA_W-1:0] r_y, r_hi, r_lo;
    logic [Z_W-1:0]    r_z;
    logic              r_done, r_err;

    logic [DATA_W-1:0] w_bus;
    logic [RIDX_W-1:0] w_bus_idx;
    logic [Z_W-1:0]    w_alu_res;
    logic              w_legal;
    logic              w_accept, w_ld_en, w_y_ld, w_z_ld, w_wb;
    logic              w_reg_we, w_hilo_we, w_wb_err;
    logic [DATA_W-1:0] w_reg_wdata, w_hi_nxt, w_lo_nxt;

`ifdef RTE_MULDIV_EN
    logic [DATA_W-1:0] r_div_q, r_div_r, r_div_d;
    logic [SH_W-1:0]   r_cnt;
    logic              r_divz;
    logic [DATA_W:0]   w_div_sh, w_div_diff;
    logic              w_div_step, w_div_last;

    assign w_div_sh   = {r_div_r, r_div_q[DATA_W-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_div_d};
    assign w_div_last = (r_cnt == SH_W'(DATA_W - 1));
`endif

    assign w_legal   = op_is_legal(r_op);
    assign w_bus     = r_regs[w_bus_idx];
    assign rd_data   = r_regs[rd_idx];
    assign req_ready = (r_state == ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign hi        = r_hi;
    assign lo        = r_lo;

    rte_alu #(
        .DATA_W (DATA_W),
        .RES_W  (Z_W)
    ) u_alu (
        .i_y   (r_y),
        .i_bus (w_bus),
        .i_op  (r_op),
        .o_res (w_alu_res)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_nxt = ST_TY;
            ST_TY:   w_state_nxt = ST_TZ;
            ST_TZ: begin
                w_state_nxt = ST_WB;
`ifdef RTE_MULDIV_EN
                if ((r_op == OP_DIV) && (w_bus != '0)) w_state_nxt = ST_TDIV;
`endif
            end
`ifdef RTE_MULDIV_EN
            ST_TDIV: if (w_div_last) w_state_nxt = ST_WB;
`endif
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state bus source, register enables and writeback selection.
    always_comb begin
        w_accept    = 1'b0;
        w_ld_en     = 1'b0;
        w_y_ld      = 1'b0;
        w_z_ld      = 1'b0;
        w_wb        = 1'b0;
        w_bus_idx   = r_ra;
        w_reg_we    = 1'b0;
        w_reg_wdata = r_z[DATA_W-1:0];
        w_hilo_we   = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_wb_err    = 1'b0;
`ifdef RTE_MULDIV_EN
        w_div_step  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_accept = req_valid;
                w_ld_en  = ld_valid;
            end
            ST_TY: w_y_ld = 1'b1;
            ST_TZ: begin
                w_bus_idx = r_rb;
                w_z_ld    = 1'b1;
            end
`ifdef RTE_MULDIV_EN
            ST_TDIV: w_div_step = 1'b1;
`endif
            ST_WB: begin
                w_wb = 1'b1;
                if (!w_legal) begin
                    w_wb_err = 1'b1;
                end else begin
                    case (r_op)
                        OP_MFHI: begin
                            w_reg_we    = 1'b1;
                            w_reg_wdata = r_hi;
                        end
                        OP_MFLO: begin
                            w_reg_we    = 1'b1;
                            w_reg_wdata = r_lo;
                        end
`ifdef RTE_MULDIV_EN
                        OP_MUL: begin
                            w_hilo_we = 1'b1;
                            w_hi_nxt  = r_z[Z_W-1:DATA_W];
                            w_lo_nxt  = r_z[DATA_W-1:0];
                        end
                        OP_DIV: begin
                            w_hilo_we = 1'b1;
                            if (r_divz) begin
                                w_hi_nxt = r_y;
                                w_lo_nxt = {DATA_W{DIV0_Q_FILL}};
                                w_wb_err = 1'b1;
                            end else begin
                                w_hi_nxt = r_div_r;
                                w_lo_nxt = r_div_q;
                            end
                        end
`endif
                        default: w_reg_we = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_op   <= '0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_rc   <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_ld_en) r_regs[ld_idx] <= ld_data;
            if (w_reg_we) r_regs[r_rc] <= w_reg_wdata;
            if (w_accept) begin
                r_op <= req_op;
                r_ra <= req_ra;
                r_rb <= req_rb;
                r_rc <= req_rc;
            end
            if (w_y_ld) r_y <= w_bus;
            if (w_z_ld) r_z <= w_alu_res;
            if (w_hilo_we) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
            end
            r_done <= w_wb;
            r_err  <= w_wb_err;
        end
    end

`ifdef RTE_MULDIV_EN
    // Restoring divider: dividend is taken from Y, divisor from the bus in T_Z.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_div_q <= '0;
            r_div_r <= '0;
            r_div_d <= '0;
            r_cnt   <= '0;
            r_divz  <= 1'b0;
        end else if (w_z_ld) begin
            r_div_q <= r_y;
            r_div_r <= '0;
            r_div_d <= w_bus;
            r_cnt   <= '0;
            r_divz  <= (w_bus == '0);
        end else if (w_div_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_div_diff[DATA_W]) begin
                r_div_r <= w_div_diff[DATA_W-1:0];
                r_div_q <= {r_div_q[DATA_W-2:0], 1'b1};
            end else begin
                r_div_r <= w_div_sh[DATA_W-1:0];
                r_div_q <= {r_div_q[DATA_W-2:0], 1'b0};
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_transfer_engine.sv
// Directed self-checking bench for reg_transfer_engine (DATA_W=32, NUM_REGS=16).
// Covers both builds; MUL/DIV vectors apply when RTE_MULDIV_EN is defined.
module tb_reg_transfer_engine;
    import rte_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [3:0]  req_ra, req_rb, req_rc;
    logic        ld_valid;
    logic [3:0]  ld_idx, rd_idx;
    logic [31:0] ld_data, rd_data, hi, lo;
    logic        done, err;

    int n_vec  = 0;
    int n_fail = 0;

    reg_transfer_engine #(.DATA_W(32), .NUM_REGS(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_rc    (req_rc),
        .ld_valid  (ld_valid),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] idx, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_idx   = idx;
        ld_data  = data;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        rd_idx = idx;
        @(posedge clk); #1;
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    // Issue one request; ld_k=0 loads alongside the request, ld_k>0 loads after edge ld_k.
    task automatic run(input string tag, input logic [4:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rc, input int ld_k,
                       input logic [3:0] lidx, input logic [31:0] ldat,
                       input int exp_lat, input logic exp_err);
        int  lat;
        logic e, rdy;
        lat = -1;
        e   = 1'b0;
        rdy = 1'b0;
        req_valid = 1'b1;
        req_op = op; req_ra = ra; req_rb = rb; req_rc = rc;
        if (ld_k == 0) begin
            ld_valid = 1'b1; ld_idx = lidx; ld_data = ldat;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ld_valid  = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; e = err; rdy = req_ready;
                break;
            end
            ld_valid = (ld_k > 0) && (k == ld_k);
            ld_idx = lidx; ld_data = ldat;
        end
        ld_valid = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_err"}, 64'(e), 64'(exp_err));
        chk({tag, "_ready"}, 64'(rdy), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] exp_hi, exp_lo;
        clr = 1'b0; req_valid = 1'b0; ld_valid = 1'b0;
        req_op = '0; req_ra = '0; req_rb = '0; req_rc = '0;
        ld_idx = '0; ld_data = '0; rd_idx = 4'd3;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_err",   64'(err), 64'd0);
        chk("rst_hi",    64'(hi), 64'd0);
        chk("rst_lo",    64'(lo), 64'd0);
        chk("rst_rd",    64'(rd_data), 64'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1;

        load(4'd1, 32'd5);
        load(4'd2, 32'd7);
        chk_reg("ld_r1", 4'd1, 32'd5);
        run("add", OP_ADD, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("add_r3", 4'd3, 32'd12);

        load(4'd1, 32'd0);
        load(4'd2, 32'd1);
        run("sub", OP_SUB, 4'd1, 4'd2, 4'd6, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("sub_r6", 4'd6, 32'hFFFF_FFFF);

        load(4'd1, 32'h8000_0001);
        load(4'd2, 32'd1);
        run("rol", OP_ROL, 4'd1, 4'd2, 4'd7, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("rol_r7", 4'd7, 32'h0000_0003);

        load(4'd1, 32'h8000_0000);
        load(4'd2, 32'd31);
        run("shra", OP_SHRA, 4'd1, 4'd2, 4'd8, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("shra_r8", 4'd8, 32'hFFFF_FFFF);
        run("shr", OP_SHR, 4'd1, 4'd2, 4'd9, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("shr_r9", 4'd9, 32'h0000_0001);
        run("neg", OP_NEG, 4'd2, 4'd0, 4'd10, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("neg_r10", 4'd10, 32'hFFFF_FFE1);

        // Same-register operands, plus a load to R5 in T_Z that must be dropped.
        load(4'd4, 32'd9);
        load(4'd5, 32'h55);
        run("selfadd", OP_ADD, 4'd4, 4'd4, 4'd4, 1, 4'd5, 32'hDEAD, 3, 1'b0);
        chk_reg("selfadd_r4", 4'd4, 32'd18);
        chk_reg("ld_ignored_r5", 4'd5, 32'h55);

        run("ldreq", OP_ADD, 4'd12, 4'd12, 4'd13, 0, 4'd12, 32'h10, 3, 1'b0);
        chk_reg("ldreq_r12", 4'd12, 32'h10);
        chk_reg("ldreq_r13", 4'd13, 32'h20);

`ifdef RTE_MULDIV_EN
        load(4'd1, 32'hFFFF_FFFD);
        load(4'd2, 32'd4);
        run("mul", OP_MUL, 4'd1, 4'd2, 4'd15, -1, 4'd0, 32'd0, 3, 1'b0);
        chk("mul_lo", 64'(lo), 64'hFFFF_FFF4);
        chk("mul_hi", 64'(hi), 64'hFFFF_FFFF);
        chk_reg("mul_rc_untouched", 4'd15, 32'd0);
        run("mflo", OP_MFLO, 4'd0, 4'd0, 4'd14, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("mflo_r14", 4'd14, 32'hFFFF_FFF4);

        load(4'd1, 32'd100);
        load(4'd2, 32'd7);
        run("div", OP_DIV, 4'd1, 4'd2, 4'd15, -1, 4'd0, 32'd0, 35, 1'b0);
        chk("div_lo", 64'(lo), 64'd14);
        chk("div_hi", 64'(hi), 64'd2);
        load(4'd2, 32'd0);
        run("div0", OP_DIV, 4'd1, 4'd2, 4'd15, -1, 4'd0, 32'd0, 3, 1'b1);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi), 64'd100);
        exp_hi = 32'd100;
        exp_lo = 32'hFFFF_FFFF;
`else
        load(4'd14, 32'h77);
        run("mflo", OP_MFLO, 4'd0, 4'd0, 4'd14, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("mflo_r14", 4'd14, 32'd0);
        run("op11", 5'd11, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 3, 1'b1);
        chk_reg("op11_r3", 4'd3, 32'd12);
        run("op12", 5'd12, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 3, 1'b1);
        chk("op12_lo", 64'(lo), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
`endif

        run("op20", 5'd20, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 3, 1'b1);
        chk_reg("op20_r3", 4'd3, 32'd12);
        chk("op20_hi", 64'(hi), 64'(exp_hi));
        chk("op20_lo", 64'(lo), 64'(exp_lo));

        // Abort mid-operation with clr; nothing may be written back or signalled.
        load(4'd1, 32'd100);
        load(4'd2, 32'd7);
        rd_idx = 4'd1;
        req_valid = 1'b1;
`ifdef RTE_MULDIV_EN
        req_op = OP_DIV;
`else
        req_op = OP_ADD;
`endif
        req_ra = 4'd1; req_rb = 4'd2; req_rc = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef RTE_MULDIV_EN
        repeat (10) @(posedge clk);
`else
        @(posedge clk);
`endif
        #1 clr = 1'b0;
        #1;
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_rd", 64'(rd_data), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 64'(done), 64'd0);
        end
        clr = 1'b1;
        @(posedge clk); #1;
        chk_reg("abort_r9", 4'd9, 32'd0);
        load(4'd1, 32'd1);
        load(4'd2, 32'd2);
        run("post_rst", OP_ADD, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 3, 1'b0);
        chk_reg("post_rst_r3", 4'd3, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_transfer_engine.md
# reg_transfer_engine

Parametrised single-bus register-transfer datapath with a built-in micro-sequencer. The generation-two replacement for the hand-driven bus datapath. An external controller issues one three-operand request (`Rc <- Ra op Rb`) per handshake. The block then runs the Y-load, Z-load and writeback bus cycles itself, plus an optional iterative divide. It sits between the instruction-decode controller and the memory/IO path and owns the general registers, HI/LO, Y and Z.

## Interface
- `DATA_W`, 32: bus, register and ALU operand width (≥8, power of 2).
- `NUM_REGS`, 16: general register count (power of 2, ≥2). `RIDX_W = $clog2(NUM_REGS)`.
- `clk` in 1: single clock, rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operation request valid.
- `req_ready` out 1: block idle and able to accept.
- `req_op` in 5: opcode.
- `req_ra`, `req_rb`, `req_rc` in RIDX_W: source A, source B, destination.
- `ld_valid` in 1: external register load, such as memory data; accepted only when `req_ready`=1.
- `ld_idx` in RIDX_W; `ld_data` in DATA_W.
- `rd_idx` in RIDX_W; `rd_data` out DATA_W: combinational read of register `rd_idx`.
- `done` out 1: one-cycle pulse when an accepted request completes.
- `err` out 1: qualifies `done`; illegal opcode or divide-by-zero.
- `hi`, `lo` out DATA_W: HI/LO contents.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG (of Ra), 10 NOT (of Ra).
  - 11 MUL, 12 DIV, 13 MFHI, 14 MFLO.
  - 15–31 are illegal.
- Arithmetic wraps modulo 2^DATA_W. Shift and rotate amounts use Rb[$clog2(DATA_W)-1:0].
- MUL: signed product, 2·DATA_W bits. HI <= upper half, LO <= lower half. Rc is not written.
- DIV: unsigned restoring divide, one quotient bit per cycle. LO <= quotient, HI <= remainder. Rc is not written.
- Divide by zero: LO <= all-ones, HI <= Ra, and `err`=1 with `done`.
- MFHI / MFLO: Rc <= HI / LO.
- Illegal opcode: no state changes; `done`=1 and `err`=1 after the normal 3-cycle latency.
- FSM states:
  - IDLE: on `req_valid`, capture op and indices and go to T_Y.
  - T_Y: Ra drives the bus; Y <= bus; go to T_Z.
  - T_Z: Rb drives the bus; Z <= ALU(Y, bus); go to T_DIV if op is DIV with a nonzero divisor, else WB.
  - T_DIV: iterate DATA_W cycles, then go to WB.
  - WB: write Rc, or HI/LO; go to IDLE.
- Any of Ra, Rb and Rc may be equal. Y and Z isolate the read from the write.
- `ld_valid` with `req_valid` in the same IDLE cycle: the load is written and the request is accepted. If `ld_idx` equals Ra or Rb, the request uses the newly loaded value.
- `ld_valid` outside IDLE is ignored.

## Timing
- Accept on the rising edge where `req_valid && req_ready`. `req_ready` = (state == IDLE).
- Non-DIV latency: Rc, HI or LO is updated on the 3rd edge after accept. `done` is high in the following cycle, with `req_ready`=1 in that same cycle. Back-to-back issue gives one request per 3 cycles.
- DIV latency: 3 + DATA_W edges.
- `ld_valid`: register is updated on the accepting edge; `rd_data` reflects it next cycle.
- Reset state while `clr`=0, asynchronously:
  - All registers, HI, LO, Y, Z = 0.
  - State = IDLE, `req_ready`=1, `done`=0, `err`=0, `hi`=`lo`=0, `rd_data`=0.
- Reset mid-operation aborts with no partial writeback and no `done`.

## Configuration
- `RTE_MULDIV_EN` defined: MUL and DIV are implemented as above, including the T_DIV state and the divider.
- `RTE_MULDIV_EN` undefined:
  - Opcodes 11 and 12 are treated as illegal; `err`=1 with `done` at 3-cycle latency.
  - No multiplier or divider logic; T_DIV is removed.
  - HI/LO remain; MFHI and MFLO still work and return 0 unless HI/LO have been written.

## Structure
- Shared package `rte_pkg`:
  - Opcode localparams.
  - FSM state enum.
  - `OP_W`=5.
  - Divide-by-zero quotient constant.
- One sub-module, `rte_alu`: combinational (Y, bus, op) -> 2·DATA_W result, covering all single-cycle ops and MUL. The iterative divider lives in the top-level FSM.

## Test plan
- Load R1=5 and R2=7 via `ld_valid`; request ADD, Rc=R3 -> `done` on cycle 4 after accept, R3=12, `err`=0.
- SUB with R1=0, R2=1 -> all-ones. ROL of 0x8000_0001 by 1 -> 0x0000_0003. SHRA of 0x8000_0000 by 31 -> 0xFFFF_FFFF.
- MUL of R1=-3 and R2=4 -> LO=0xFFFF_FFF4, HI=0xFFFF_FFFF. DIV 100/7 -> LO=14, HI=2, `done` at 3+32 cycles. DIV by 0 -> LO=0xFFFF_FFFF, HI=100, `err`=1.
- Opcode 20 -> `done`=1, `err`=1, all registers unchanged. Without `RTE_MULDIV_EN`, opcode 11 behaves the same way.
- Request ADD R4 <- R4 + R4 with R4=9 -> R4=18. `ld_valid` to R5 during T_Z is ignored.
- Drop `clr` during T_DIV -> all outputs are at reset values immediately, no `done` pulse, and a new request is accepted after `clr` releases.
